demux_r1_4ph_sync: RTL and testbench
====================================

# demux_r1_4ph_sync

Clocked single-rail 4-phase demultiplexer that steers one incoming request channel (r0/a0) to one of two outgoing channels (r1/a1, r2/a2) under a bundled select bit. It is the responder-side counterpart of the 4-phase arbiter: the arbiter merges two requesters onto one channel, while this block receives a single channel and fans it back out to two responders. All handshake inputs are asynchronous and are brought into the clock domain through synchronizers. Every output is a register.

## Interface
Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer; legal values are 2 or more.
- CNT_W, 8, width of each completed-transaction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- r0  input  1  incoming request (asynchronous).
- sel  input  1  route select bundled with r0: 0 routes to channel 1, 1 routes to channel 2. The sender holds it stable from before r0 rises until a0 rises.
- a0  output  1  acknowledge to the incoming channel.
- r1  output  1  request to responder 1.
- a1  input  1  acknowledge from responder 1 (asynchronous).
- r2  output  1  request to responder 2.
- a2  input  1  acknowledge from responder 2 (asynchronous).
- err  output  1  sticky protocol-error flag.
- cnt1  output  CNT_W  completed transactions on channel 1.
- cnt2  output  CNT_W  completed transactions on channel 2.

## Operation
- Synchronizers: r0, a1 and a2 each pass through a SYNC_STAGES flop chain. The synchronized outputs are r0_s, a1_s and a2_s. sel is not synchronized; the bundling constraint guarantees it is stable.
- Latched route `ch` (1 bit) is captured from sel on the IDLE to FWD transition. Changes on sel at any other time are ignored.
- FSM states and transitions:
  - IDLE: all of a0, r1 and r2 are 0. When r0_s = 1, latch ch = sel, assert r[ch] and go to FWD.
  - FWD: hold r[ch] = 1. When a[ch]_s = 1, assert a0 and go to HOLD.
  - HOLD: hold r[ch] = 1 and a0 = 1. When r0_s = 0, deassert r[ch] and go to RTZ.
  - RTZ: a0 = 1, r[ch] = 0. When a[ch]_s = 0, deassert a0, increment cnt[ch] and go to IDLE.
- The full handshake order is: r0↑ → r[ch]↑ → a[ch]↑ → a0↑ → r0↓ → r[ch]↓ → a[ch]↓ → a0↓.
- Counters: modulo 2^CNT_W. An increment from all-ones wraps to 0 without raising err.
- err is set, and stays set until reset, in either of these cases:
  - a1_s or a2_s is 1 while in IDLE;
  - the acknowledge of the non-selected channel is 1 in FWD, HOLD or RTZ.
- Setting err does not change the FSM path.
- The non-selected request stays 0 for the whole transaction. r1 and r2 are never 1 together.

## Timing
- Reset values: a0 = 0, r1 = 0, r2 = 0, err = 0, cnt1 = 0, cnt2 = 0. The FSM is in IDLE and all synchronizer flops are 0.
- Reset is asynchronous: outputs clear as soon as rstn falls, including mid-transaction. The environment must reset its own side too.
- If r0 is still high after rstn releases, it is handled as a fresh request once it has been synchronized.
- Forward latency: an input edge that meets setup before clock edge k is visible on the synchronized signal after edge k+SYNC_STAGES−1. The resulting output change appears after edge k+SYNC_STAGES. With the default SYNC_STAGES = 2, each output reacts on the 3rd rising edge after the input edge.
- Minimum full transaction with instant responders, for the default: 4 × 3 = 12 cycles from r0↑ to a0↓.
- Back-to-back transactions: a new r0↑ may arrive once a0 = 0. IDLE re-samples r0_s on the next edge, and no idle cycles are inserted.
- cnt[ch] updates on the same edge on which a0 falls.

## Test plan
- Route to channel 1: with sel = 0, raise r0 at cycle 0 while responder 1 echoes immediately.
  - r1 = 1 after edge 3, a0 = 1 after edge 6.
  - Drop r0: r1 = 0 three edges later, a0 = 0 three edges after a1 falls.
  - Final state: cnt1 = 1, cnt2 = 0, r2 stays 0 throughout, err = 0.
- Route to channel 2 with sel toggled after r0 rises: with sel = 1 at r0↑, toggle sel after edge 3.
  - Only r2 is asserted; r1 stays 0.
  - Final state: cnt2 = 1, err = 0.
- Slow responder: a2 is delayed 20 cycles.
  - a0 stays 0 until 3 edges after a2↑.
  - r2 is held for the whole wait; no timeout.
- Protocol error cases:
  - Pulse a1 in IDLE → err = 1 three edges later, and it stays 1 through a following clean transaction.
  - Separately, assert a1 during a channel-2 transaction → err = 1.
- Reset mid-transaction: drop rstn while in HOLD.
  - a0, r1, r2, err and the counters go to 0 with no clock edge.
  - Release rstn with r0 = 0: the next transaction completes normally.
- Counter wrap: run 256 channel-1 transactions with CNT_W = 8.
  - cnt1 wraps from 255 to 0, cnt2 = 0, err = 0.

Source files
------------

// File: rtl/demux_r1_4ph_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : demux_r1_4ph_sync                                          |
// | Description : Clocked single-rail 4-phase demultiplexer. One incoming    |
// |               request channel (r0/a0) is steered to responder 1 or 2     |
// |               under a bundled select bit. Handshake inputs are           |
// |               synchronized; all outputs are registers.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module demux_r1_4ph_sync #(
  parameter int SYNC_STAGES = 2,  // flops per input synchronizer, 2 or more
  parameter int CNT_W       = 8   // width of each completed-transaction counter
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             r0,
  input  logic             sel,
  output logic             a0,
  output logic             r1,
  input  logic             a1,
  output logic             r2,
  input  logic             a2,
  output logic             err,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    HOLD = 2'd2,
    RTZ  = 2'd3
  } state_t;

  // Synchronizer chains; the last flop of each chain is the clock-domain view.
  logic [SYNC_STAGES-1:0] r0_sync;
  logic [SYNC_STAGES-1:0] a1_sync;
  logic [SYNC_STAGES-1:0] a2_sync;
  logic                   r0_s;
  logic                   a1_s;
  logic                   a2_s;

  state_t                 state;
  state_t                 state_nxt;
  logic                   ch;        // latched route: 0 = channel 1, 1 = channel 2
  logic                   ch_nxt;
  logic                   a0_nxt;
  logic                   r1_nxt;
  logic                   r2_nxt;
  logic                   err_nxt;
  logic [CNT_W-1:0]       cnt1_nxt;
  logic [CNT_W-1:0]       cnt2_nxt;
  logic                   ack_sel;   // acknowledge of the routed channel
  logic                   ack_oth;   // acknowledge of the other channel

  // Shift each asynchronous handshake input through its synchronizer chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_sync <= '0;
      a1_sync <= '0;
      a2_sync <= '0;
    end else begin
      r0_sync <= {r0_sync[SYNC_STAGES-2:0], r0};
      a1_sync <= {a1_sync[SYNC_STAGES-2:0], a1};
      a2_sync <= {a2_sync[SYNC_STAGES-2:0], a2};
    end
  end

  assign r0_s = r0_sync[SYNC_STAGES-1];
  assign a1_s = a1_sync[SYNC_STAGES-1];
  assign a2_s = a2_sync[SYNC_STAGES-1];

  // The route is latched, so sel is only consulted on the IDLE exit.
  assign ack_sel = ch ? a2_s : a1_s;
  assign ack_oth = ch ? a1_s : a2_s;

  // State, route, output and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ch    <= 1'b0;
      a0    <= 1'b0;
      r1    <= 1'b0;
      r2    <= 1'b0;
      err   <= 1'b0;
      cnt1  <= '0;
      cnt2  <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      a0    <= a0_nxt;
      r1    <= r1_nxt;
      r2    <= r2_nxt;
      err   <= err_nxt;
      cnt1  <= cnt1_nxt;
      cnt2  <= cnt2_nxt;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead so
  // every port is driven straight from a flop.
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    a0_nxt    = a0;
    r1_nxt    = r1;
    r2_nxt    = r2;
    err_nxt   = err;
    cnt1_nxt  = cnt1;
    cnt2_nxt  = cnt2;

    case (state)
      IDLE: begin
        a0_nxt = 1'b0;
        r1_nxt = 1'b0;
        r2_nxt = 1'b0;
        // No responder may acknowledge while nothing is outstanding.
        if (a1_s || a2_s) begin
          err_nxt = 1'b1;
        end
        if (r0_s) begin
          ch_nxt    = sel;
          r1_nxt    = ~sel;
          r2_nxt    = sel;
          state_nxt = FWD;
        end
      end
      FWD: begin
        if (ack_oth) begin
          err_nxt = 1'b1;
        end
        if (ack_sel) begin
          a0_nxt    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ack_oth) begin
          err_nxt = 1'b1;
        end
        if (!r0_s) begin
          r1_nxt    = 1'b0;
          r2_nxt    = 1'b0;
          state_nxt = RTZ;
        end
      end
      RTZ: begin
        if (ack_oth) begin
          err_nxt = 1'b1;
        end
        // Transaction completes when the routed acknowledge returns to zero;
        // the counter steps on the same edge a0 falls and wraps silently.
        if (!ack_sel) begin
          a0_nxt    = 1'b0;
          state_nxt = IDLE;
          if (ch) begin
            cnt2_nxt = cnt2 + CNT_W'(1);
          end else begin
            cnt1_nxt = cnt1 + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_r1_4ph_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_demux_r1_4ph_sync                                       |
// | Description : Directed self-checking bench for demux_r1_4ph_sync.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_demux_r1_4ph_sync;

  logic       clk = 1'b0;
  logic       rstn;
  logic       r0;
  logic       sel;
  logic       a0;
  logic       r1;
  logic       a1;
  logic       r2;
  logic       a2;
  logic       err;
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Responder model controls.
  logic resp_en1  = 1'b0;
  logic resp_en2  = 1'b0;
  int   resp_dly  = 0;
  int   dly1      = 0;
  int   dly2      = 0;

  // Output activity monitor counters.
  int r1_hi   = 0;
  int r2_hi   = 0;
  int both_hi = 0;

  demux_r1_4ph_sync #(
    .SYNC_STAGES(2),
    .CNT_W      (8)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .r0  (r0),
    .sel (sel),
    .a0  (a0),
    .r1  (r1),
    .a1  (a1),
    .r2  (r2),
    .a2  (a2),
    .err (err),
    .cnt1(cnt1),
    .cnt2(cnt2)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count cycles where each request is high, and any overlap.
  always @(posedge clk) begin
    #1;
    if (r1 === 1'b1) r1_hi++;
    if (r2 === 1'b1) r2_hi++;
    if (r1 === 1'b1 && r2 === 1'b1) both_hi++;
  end

  // Responders echo their request after resp_dly cycles, on falling edges.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en1) begin
        if (a1 !== r1) begin
          if (dly1 >= resp_dly) begin
            a1   = r1;
            dly1 = 0;
          end else begin
            dly1++;
          end
        end else begin
          dly1 = 0;
        end
      end
      if (resp_en2) begin
        if (a2 !== r2) begin
          if (dly2 >= resp_dly) begin
            a2   = r2;
            dly2 = 0;
          end else begin
            dly2++;
          end
        end else begin
          dly2 = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for a0 to reach v.
  task automatic wait_a0(input logic v, input string tag);
    int n;
    n = 0;
    while (a0 !== v && n < 400) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, a0}, {31'd0, v});
  endtask

  // Full transaction with the responder model answering.
  task automatic do_txn(input logic s);
    @(negedge clk);
    sel = s;
    r0  = 1'b1;
    wait_a0(1'b1, "txn_a0_rise");
    @(negedge clk);
    r0 = 1'b0;
    wait_a0(1'b0, "txn_a0_fall");
  endtask

  task automatic do_reset();
    @(negedge clk);
    resp_en1 = 1'b0;
    resp_en2 = 1'b0;
    rstn = 1'b0;
    r0   = 1'b0;
    sel  = 1'b0;
    a1   = 1'b0;
    a2   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    resp_dly = 0;
    dly1 = 0;
    dly2 = 0;
    resp_en1 = 1'b1;
    resp_en2 = 1'b1;
  endtask

  initial begin
    int n;
    int r2_low;

    rstn = 1'b0;
    r0   = 1'b0;
    sel  = 1'b0;
    a1   = 1'b0;
    a2   = 1'b0;
    #1;
    // Reset values, before any clock edge.
    check("rst_a0",   {31'd0, a0},  32'd0);
    check("rst_r1",   {31'd0, r1},  32'd0);
    check("rst_r2",   {31'd0, r2},  32'd0);
    check("rst_err",  {31'd0, err}, 32'd0);
    check("rst_cnt1", {24'd0, cnt1}, 32'd0);
    check("rst_cnt2", {24'd0, cnt2}, 32'd0);

    do_reset();

    // Route to channel 1 with an immediate responder; exact edge timing.
    @(negedge clk);
    r1_hi = 0; r2_hi = 0; both_hi = 0;
    sel = 1'b0;
    r0  = 1'b1;
    tick(2);
    check("c1_r1_edge2", {31'd0, r1}, 32'd0);
    tick(1);
    check("c1_r1_edge3", {31'd0, r1}, 32'd1);
    tick(2);
    check("c1_a0_edge5", {31'd0, a0}, 32'd0);
    tick(1);
    check("c1_a0_edge6", {31'd0, a0}, 32'd1);
    @(negedge clk);
    r0 = 1'b0;
    tick(2);
    check("c1_r1_hold",  {31'd0, r1}, 32'd1);
    tick(1);
    check("c1_r1_fall",  {31'd0, r1}, 32'd0);
    tick(2);
    check("c1_a0_hold",  {31'd0, a0}, 32'd1);
    tick(1);
    check("c1_a0_fall",  {31'd0, a0}, 32'd0);
    check("c1_cnt1",     {24'd0, cnt1}, 32'd1);
    check("c1_cnt2",     {24'd0, cnt2}, 32'd0);
    check("c1_err",      {31'd0, err},  32'd0);
    check("c1_r2_never", r2_hi, 0);

    // Route to channel 2; sel toggles after edge 3 and must be ignored.
    @(negedge clk);
    r1_hi = 0;
    sel = 1'b1;
    r0  = 1'b1;
    tick(3);
    check("c2_r2_edge3", {31'd0, r2}, 32'd1);
    check("c2_r1_edge3", {31'd0, r1}, 32'd0);
    @(negedge clk);
    sel = 1'b0;
    wait_a0(1'b1, "c2_a0_rise");
    @(negedge clk);
    r0 = 1'b0;
    wait_a0(1'b0, "c2_a0_fall");
    check("c2_r1_never", r1_hi, 0);
    check("c2_cnt2",     {24'd0, cnt2}, 32'd1);
    check("c2_cnt1",     {24'd0, cnt1}, 32'd1);
    check("c2_err",      {31'd0, err},  32'd0);

    // Slow responder on channel 2.
    do_reset();
    resp_dly = 20;
    @(negedge clk);
    sel = 1'b1;
    r0  = 1'b1;
    tick(3);
    check("slow_r2_up", {31'd0, r2}, 32'd1);
    n = 0;
    r2_low = 0;
    while (a2 !== 1'b1 && n < 400) begin
      tick(1);
      if (r2 !== 1'b1) r2_low++;
      if (a2 !== 1'b1 && a0 !== 1'b0) r2_low++;
      n++;
    end
    check("slow_waited",  {31'd0, (n > 15)}, 32'd1);
    check("slow_r2_held", r2_low, 0);
    check("slow_a0_e1",   {31'd0, a0}, 32'd0);
    tick(1);
    check("slow_a0_e2",   {31'd0, a0}, 32'd0);
    tick(1);
    check("slow_a0_e3",   {31'd0, a0}, 32'd1);
    @(negedge clk);
    r0 = 1'b0;
    wait_a0(1'b0, "slow_a0_fall");
    check("slow_cnt2", {24'd0, cnt2}, 32'd1);

    // Acknowledge pulse while idle raises a sticky error.
    do_reset();
    resp_en1 = 1'b0;
    @(negedge clk);
    a1 = 1'b1;
    @(negedge clk);
    a1 = 1'b0;
    resp_en1 = 1'b1;
    tick(1);
    check("err_idle_e2", {31'd0, err}, 32'd0);
    tick(1);
    check("err_idle_e3", {31'd0, err}, 32'd1);
    do_txn(1'b0);
    check("err_sticky",  {31'd0, err},  32'd1);
    check("err_txn_cnt", {24'd0, cnt1}, 32'd1);

    // Wrong-channel acknowledge during a channel-2 transaction.
    do_reset();
    resp_en1 = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    r0  = 1'b1;
    tick(3);
    check("err2_pre", {31'd0, err}, 32'd0);
    @(negedge clk);
    a1 = 1'b1;
    @(negedge clk);
    a1 = 1'b0;
    tick(2);
    check("err2_set", {31'd0, err}, 32'd1);
    wait_a0(1'b1, "err2_a0_rise");
    @(negedge clk);
    r0 = 1'b0;
    wait_a0(1'b0, "err2_a0_fall");
    check("err2_cnt2", {24'd0, cnt2}, 32'd1);
    check("err2_err",  {31'd0, err},  32'd1);

    // Asynchronous reset while in HOLD.
    do_reset();
    @(negedge clk);
    sel = 1'b0;
    r0  = 1'b1;
    wait_a0(1'b1, "mid_a0_rise");
    tick(1);
    #2;
    resp_en1 = 1'b0;
    resp_en2 = 1'b0;
    rstn = 1'b0;
    r0   = 1'b0;
    a1   = 1'b0;
    a2   = 1'b0;
    #1;
    check("mid_a0",  {31'd0, a0},  32'd0);
    check("mid_r1",  {31'd0, r1},  32'd0);
    check("mid_r2",  {31'd0, r2},  32'd0);
    check("mid_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    resp_en1 = 1'b1;
    resp_en2 = 1'b1;
    do_txn(1'b0);
    check("mid_cnt1", {24'd0, cnt1}, 32'd1);
    check("mid_cnt2", {24'd0, cnt2}, 32'd0);

    // Counter wrap on channel 1, back-to-back.
    do_reset();
    both_hi = 0;
    for (int i = 0; i < 256; i++) begin
      do_txn(1'b0);
      if (i == 254) check("wrap_255", {24'd0, cnt1}, 32'd255);
    end
    check("wrap_0",    {24'd0, cnt1}, 32'd0);
    check("wrap_cnt2", {24'd0, cnt2}, 32'd0);
    check("wrap_err",  {31'd0, err},  32'd0);
    check("no_overlap", both_hi, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
